datapath_trace_unit: RTL
========================

# datapath_trace_unit

Synthesisable retirement-trace and instruction-profiling block that sits beside `datapath` and watches its `pc`, `opcode` and `result` outputs. Each retired instruction is classified by opcode into one of seven classes, counted in per-class saturating counters, and optionally queued into a trace FIFO drained by a valid/ready consumer such as a debug UART or bench scoreboard. It is the parametrised successor to the simulation-only opcode print monitor: widths, FIFO depth and class filtering are configurable, and it adds buffering, counting and overflow accounting.

## Interface
- `PC_W`, default 8: width of the `pc` input.
- `DATA_W`, default 32: width of the `result` input.
- `DEPTH`, default 16: trace FIFO entries; a power of two, at least 2.
- `CNT_W`, default 16: width of each class counter and of the drop counter.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `retire_valid`  in  1  one instruction retires this cycle.
- `pc`  in  PC_W  PC of the retiring instruction.
- `opcode`  in  6  opcode of the retiring instruction.
- `result`  in  DATA_W  datapath result of the retiring instruction.
- `class_mask`  in  7  bit k=1 lets class k enter the FIFO; counting ignores the mask.
- `tr_valid`  out  1  FIFO head entry available.
- `tr_ready`  in  1  consumer accepts the head entry.
- `tr_data`  out  9+PC_W+DATA_W  head entry: {class[2:0], opcode[5:0], pc, result}.
- `cnt_sel`  in  3  selects counter 0–6 = class, 7 = drop counter.
- `cnt_data`  out  CNT_W  registered value of the selected counter.
- `overflow`  out  1  sticky flag: at least one entry was dropped.
- `halt`  out  1  sticky illegal-opcode halt; constant 0 unless the macro is defined.

## Operation
- Opcode classes:
  - 0 R-ALU: opcodes 0–5 and 15 (MUL).
  - 1 I-ALU: opcodes 6–10 and 14 (LUI).
  - 2 LOAD: opcodes 11–13.
  - 3 STORE: opcodes 16–18.
  - 4 BRANCH: opcodes 19–21.
  - 5 JUMP: opcodes 22–24.
  - 6 ILLEGAL: opcodes 25–63.
- Per retirement (`retire_valid`=1 and not halted):
  - The class counter increments and saturates at all-ones; it never wraps.
  - If `class_mask[class]`=1 the entry is pushed to the FIFO.
  - If the FIFO is full and no pop occurs the same cycle, the entry is dropped: the drop counter increments (saturating) and `overflow` sets.
- FIFO is show-ahead: `tr_data` = head entry whenever `tr_valid`=1. A pop occurs when `tr_valid` and `tr_ready` are both 1.
- `tr_data` is held stable while `tr_valid`=1 and `tr_ready`=0.
- Full FIFO with a simultaneous push and pop: both succeed, occupancy is unchanged, nothing is dropped.
- Empty FIFO with a push: no pop is possible that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- `cnt_data` ← counter[`cnt_sel`] each cycle. It shows the pre-update value when an increment occurs in the same cycle.

## Timing
- Reset (async assert, synchronous deassert expected upstream):
  - FIFO empty, `tr_valid`=0, `tr_data`=0.
  - All counters 0, `cnt_data`=0, `overflow`=0, `halt`=0.
- Reset mid-operation discards all queued entries and counts immediately.
- Push-to-visible latency: an entry accepted on edge N gives `tr_valid`=1 after edge N. Minimum retire-to-consume latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained.
- `cnt_data` latency: 1 cycle from a `cnt_sel` change.
- `overflow` and `halt` clear only on reset.

## Configuration
- `TRACE_ILLEGAL_HALT_EN` defined:
  - A retirement of class ILLEGAL is counted and pushed (subject to the mask), then sets `halt` on the same edge.
  - While `halt`=1, further retirements are ignored: no count, push or drop.
  - The FIFO still drains while halted.
- `TRACE_ILLEGAL_HALT_EN` not defined: `halt` is tied to 0 and ILLEGAL is treated like any other class.

## Test plan
- Reset, then retire opcodes 0, 6, 11, 16, 19, 22, 40 with `class_mask`=7'h7F and `tr_ready`=1 → seven entries emerge in order with class 0..6; each class counter reads 1 via `cnt_sel`.
- DEPTH=16, `tr_ready`=0, 20 retirements → `tr_valid`=1, 16 entries queued, drop counter=4, `overflow`=1. Raising `tr_ready` then drains the first 16 PCs in order.
- Full FIFO, `retire_valid`=1 and `tr_ready`=1 in the same cycle → no drop, occupancy stays 16, new entry appears last.
- `class_mask`=7'h01, retire opcode 19 five times → class-4 counter=5, `tr_valid` stays 0.
- CNT_W=4, 20 retirements of opcode 0 → class-0 counter holds 15.
- With `TRACE_ILLEGAL_HALT_EN`: retire 40 then 0 → `halt`=1, ILLEGAL counter=1, R-ALU counter=0. Asserting `rst_n`=0 mid-stream clears everything within the same cycle.

Source files
------------

// File: rtl/datapath_trace_unit.sv
// datapath_trace_unit: classifies retiring instructions by opcode, keeps
// per-class saturating counters and a drop counter, and queues trace
// entries {class, opcode, pc, result} in a show-ahead FIFO drained by a
// valid/ready consumer.
// Optional feature: define TRACE_ILLEGAL_HALT_EN to make an ILLEGAL-class
// retirement raise a sticky halt that freezes further tracing and counting.
module datapath_trace_unit #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       retire_valid,
  input  logic [PC_W-1:0]            pc,
  input  logic [5:0]                 opcode,
  input  logic [DATA_W-1:0]          result,
  input  logic [6:0]                 class_mask,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [9+PC_W+DATA_W-1:0]   tr_data,
  input  logic [2:0]                 cnt_sel,
  output logic [CNT_W-1:0]           cnt_data,
  output logic                       overflow,
  output logic                       halt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 9 + PC_W + DATA_W;

  typedef enum logic [2:0] {
    CLS_RALU    = 3'd0,
    CLS_IALU    = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } cls_e;

  cls_e             cls;
  logic             halt_q;
  logic             accept;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [CNT_W-1:0] cnt_data_q;
  logic             ovf_q;

  // Opcode to class decode
  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode inside {[6'd0:6'd5], 6'd15})        cls = CLS_RALU;
    else if (opcode inside {[6'd6:6'd10], 6'd14})  cls = CLS_IALU;
    else if (opcode inside {[6'd11:6'd13]})        cls = CLS_LOAD;
    else if (opcode inside {[6'd16:6'd18]})        cls = CLS_STORE;
    else if (opcode inside {[6'd19:6'd21]})        cls = CLS_BRANCH;
    else if (opcode inside {[6'd22:6'd24]})        cls = CLS_JUMP;
  end

  // Push/pop/drop decisions and FIFO pointer/occupancy next state
  always_comb begin
    accept   = retire_valid && !halt_q;
    full     = (occ_q == (AW+1)'(DEPTH));
    pop      = tr_valid && tr_ready;
    push_req = accept && class_mask[cls];
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = pop  ? rptr_q + AW'(1) : rptr_q;
    occ_d    = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Saturating class and drop counter next state
  always_comb begin
    for (int unsigned k = 0; k < 8; k++) cnt_d[k] = cnt_q[k];
    if (accept && cnt_q[cls] != '1) cnt_d[cls] = cnt_q[cls] + CNT_W'(1);
    if (drop && cnt_q[7] != '1)     cnt_d[7]   = cnt_q[7] + CNT_W'(1);
  end

  // Control state: pointers, occupancy, counters, readout, overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      cnt_data_q <= '0;
      ovf_q      <= 1'b0;
      for (int unsigned k = 0; k < 8; k++) cnt_q[k] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      cnt_data_q <= cnt_q[cnt_sel];
      ovf_q      <= ovf_q | drop;
      for (int unsigned k = 0; k < 8; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // Trace storage; contents are only visible through a valid head pointer
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {cls, opcode, pc, result};
  end

`ifdef TRACE_ILLEGAL_HALT_EN
  // Sticky halt raised by an accepted ILLEGAL retirement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else if (accept && cls == CLS_ILLEGAL) halt_q <= 1'b1;
  end
`else
  assign halt_q = 1'b0;
`endif

  assign tr_valid = (occ_q != '0);
  // Gate the head with valid so the empty/reset output reads zero
  assign tr_data  = tr_valid ? mem[rptr_q] : '0;
  assign cnt_data = cnt_data_q;
  assign overflow = ovf_q;
  assign halt     = halt_q;

endmodule
